// File: rtl/imm_ext_arbiter_if.sv
// rtl/imm_ext_arbiter_if.sv - requester, extension-unit and result signals of imm_ext_arbiter
// Ports (slave = arbiter side):
//   req0_*/req1_*  : valid, imm[7:0], wide (zext with IMM_ZERO_EXT_EN) in; ready out
//   ext_a[7:0] out / ext_r[15:0] in : shared SignExtend_8bit unit
//   out_valid, out_imm[15:0], out_id out; out_ready in
// Macro IMM_ZERO_EXT_EN adds req0_zext / req1_zext.
interface imm_ext_arbiter_if;
    logic        req0_valid;
    logic [7:0]  req0_imm;
    logic        req0_wide;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_imm;
    logic        req1_wide;
    logic        req1_ready;
`ifdef IMM_ZERO_EXT_EN
    logic        req0_zext;
    logic        req1_zext;
`endif
    logic [7:0]  ext_a;
    logic [15:0] ext_r;
    logic        out_valid;
    logic [15:0] out_imm;
    logic        out_id;
    logic        out_ready;

    modport slave (
        input  req0_valid, req0_imm, req0_wide,
        input  req1_valid, req1_imm, req1_wide,
`ifdef IMM_ZERO_EXT_EN
        input  req0_zext, req1_zext,
`endif
        input  ext_r, out_ready,
        output req0_ready, req1_ready, ext_a,
        output out_valid, out_imm, out_id
    );

    modport master (
        output req0_valid, req0_imm, req0_wide,
        output req1_valid, req1_imm, req1_wide,
`ifdef IMM_ZERO_EXT_EN
        output req0_zext, req1_zext,
`endif
        output ext_r, out_ready,
        input  req0_ready, req1_ready, ext_a,
        input  out_valid, out_imm, out_id
    );
endinterface

// File: rtl/imm_ext_arbiter.sv
// rtl/imm_ext_arbiter.sv - round-robin sharing of the 8->16 sign-extension unit between two immediate requesters
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : imm_ext_arbiter_if.slave (requester beats, ext unit a/r, registered result handshake)
// Macro IMM_ZERO_EXT_EN: narrow beats with zext=1 produce {8'h00, imm} instead of ext_r.
module imm_ext_arbiter (
    input  logic               clk,
    input  logic               reset,
    imm_ext_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WIDE_WAIT = 2'd1,
        OUT_HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic        rr_ptr;
    logic        owner;
    logic        contended;
    logic [7:0]  hi_reg;
    logic        out_valid_q;
    logic [15:0] out_imm_q;
    logic        out_id_q;

    logic        both_valid;
    logic        any_valid;
    logic        grant_id;
    logic        sel_id;
    logic [7:0]  sel_imm;
    logic        sel_wide;
    logic        ready0;
    logic        ready1;
    logic        accept;
    logic [15:0] narrow_val;

    always_comb begin
        both_valid = bus.req0_valid & bus.req1_valid;
        any_valid  = bus.req0_valid | bus.req1_valid;
        // rr_ptr only matters under contention; a lone requester always wins.
        grant_id   = both_valid ? rr_ptr : bus.req1_valid;
        // The low byte of a wide immediate comes from the locked owner.
        sel_id     = (state == WIDE_WAIT) ? owner : grant_id;
        sel_imm    = sel_id ? bus.req1_imm  : bus.req0_imm;
        sel_wide   = sel_id ? bus.req1_wide : bus.req0_wide;

        ready0 = 1'b0;
        ready1 = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    ready0 = any_valid & ~grant_id;
                    ready1 = any_valid &  grant_id;
                end
                WIDE_WAIT: begin
                    ready0 = ~owner;
                    ready1 =  owner;
                end
                default: begin
                    ready0 = 1'b0;
                    ready1 = 1'b0;
                end
            endcase
        end
        accept = (ready0 & bus.req0_valid) | (ready1 & bus.req1_valid);

        bus.ext_a = (!reset && state == IDLE && any_valid) ? sel_imm : 8'h00;

`ifdef IMM_ZERO_EXT_EN
        if (sel_id ? bus.req1_zext : bus.req0_zext)
            narrow_val = {8'h00, sel_imm};
        else
            narrow_val = bus.ext_r;
`else
        narrow_val = bus.ext_r;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            contended   <= 1'b0;
            hi_reg      <= 8'h00;
            out_valid_q <= 1'b0;
            out_imm_q   <= 16'h0000;
            out_id_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        contended <= both_valid;
                        if (sel_wide) begin
                            hi_reg <= sel_imm;
                            owner  <= grant_id;
                            state  <= WIDE_WAIT;
                        end else begin
                            out_imm_q   <= narrow_val;
                            out_id_q    <= grant_id;
                            out_valid_q <= 1'b1;
                            state       <= OUT_HOLD;
                        end
                    end
                end
                WIDE_WAIT: begin
                    if (accept) begin
                        out_imm_q   <= {hi_reg, sel_imm};
                        out_id_q    <= owner;
                        out_valid_q <= 1'b1;
                        state       <= OUT_HOLD;
                    end
                end
                OUT_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                        // Hand priority to the loser only if there was one.
                        if (contended)
                            rr_ptr <= ~out_id_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_imm    = out_imm_q;
    assign bus.out_id     = out_id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb/tb_imm_ext_arbiter.sv - directed self-checking bench for imm_ext_arbiter
module tb_imm_ext_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    imm_ext_arbiter_if bus ();

    // Model of the external SignExtend_8bit unit.
    assign bus.ext_r = {{8{bus.ext_a[7]}}, bus.ext_a};

    imm_ext_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0b exp=%0b", name, got, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_imm   = 8'h55;
        bus.req1_valid = 1'b1;
        bus.req1_imm   = 8'h66;
        tick();
        tick();
        chk1("reset_ready0", bus.req0_ready, 1'b0);
        chk1("reset_ready1", bus.req1_ready, 1'b0);
        chk1("reset_out_valid", bus.out_valid, 1'b0);
        chk16("reset_out_imm", bus.out_imm, 16'h0000);
        chk1("reset_out_id", bus.out_id, 1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_narrow();
        bus.out_ready  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_imm   = 8'h80;
        bus.req0_wide  = 1'b0;
        #1;
        chk1("narrow0_ready0", bus.req0_ready, 1'b1);
        chk1("narrow0_ready1", bus.req1_ready, 1'b0);
        chk16("narrow0_ext_a", {8'h00, bus.ext_a}, 16'h0080);
        tick();
        bus.req0_valid = 1'b0;
        chk1("narrow0_out_valid", bus.out_valid, 1'b1);
        chk16("narrow0_out_imm", bus.out_imm, 16'hFF80);
        chk1("narrow0_out_id", bus.out_id, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk1("narrow0_valid_fall", bus.out_valid, 1'b0);
        bus.out_ready  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_imm   = 8'h7F;
        bus.req1_wide  = 1'b0;
        #1;
        chk1("narrow1_ready1", bus.req1_ready, 1'b1);
        chk1("narrow1_ready0", bus.req0_ready, 1'b0);
        tick();
        bus.req1_valid = 1'b0;
        chk1("narrow1_out_valid", bus.out_valid, 1'b1);
        chk16("narrow1_out_imm", bus.out_imm, 16'h007F);
        chk1("narrow1_out_id", bus.out_id, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        chk1("narrow1_valid_fall", bus.out_valid, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_imm [3];
        logic        exp_id  [3];
        int          n;
        exp_imm[0] = 16'h0001; exp_id[0] = 1'b0;
        exp_imm[1] = 16'h0002; exp_id[1] = 1'b1;
        exp_imm[2] = 16'h0001; exp_id[2] = 1'b0;
        n = 0;
        bus.out_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_imm = 8'h01; bus.req0_wide = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_imm = 8'h02; bus.req1_wide = 1'b0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                chk16($sformatf("rr_imm_%0d", n), bus.out_imm, exp_imm[n]);
                chk1($sformatf("rr_id_%0d", n), bus.out_id, exp_id[n]);
                n++;
            end
        end
        if (n < 3) begin
            checks++;
            failures++;
            $display("FAIL rr_timeout got=%0d results exp=3", n);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk1("rr_drain", bus.out_valid, 1'b0);
    endtask

    // rr_ptr points at requester 1 after the round-robin sequence, so req1
    // wins the contended high byte here.
    task automatic test_wide();
        bus.out_ready  = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_imm = 8'h12; bus.req1_wide = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_imm = 8'h33; bus.req0_wide = 1'b0;
        #1;
        chk1("wide_hi_ready1", bus.req1_ready, 1'b1);
        chk1("wide_hi_ready0", bus.req0_ready, 1'b0);
        tick();
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1($sformatf("wide_stall_ready0_%0d", i), bus.req0_ready, 1'b0);
            chk1($sformatf("wide_stall_valid_%0d", i), bus.out_valid, 1'b0);
        end
        bus.req1_valid = 1'b1; bus.req1_imm = 8'hF4; bus.req1_wide = 1'b1;
        #1;
        chk1("wide_lo_ready1", bus.req1_ready, 1'b1);
        chk1("wide_lo_ready0", bus.req0_ready, 1'b0);
        tick();
        bus.req1_valid = 1'b0;
        chk1("wide_out_valid", bus.out_valid, 1'b1);
        chk16("wide_out_imm", bus.out_imm, 16'h12F4);
        chk1("wide_out_id", bus.out_id, 1'b1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1($sformatf("bp_valid_%0d", i), bus.out_valid, 1'b1);
            chk16($sformatf("bp_imm_%0d", i), bus.out_imm, 16'h12F4);
            chk1($sformatf("bp_id_%0d", i), bus.out_id, 1'b1);
            chk1($sformatf("bp_ready0_%0d", i), bus.req0_ready, 1'b0);
            chk1($sformatf("bp_ready1_%0d", i), bus.req1_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk1("bp_valid_fall", bus.out_valid, 1'b0);
        // The stalled req0 beat is served from IDLE now.
        chk1("bp_req0_served_ready", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        chk16("bp_req0_imm", bus.out_imm, 16'h0033);
        chk1("bp_req0_id", bus.out_id, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk1("bp_req0_fall", bus.out_valid, 1'b0);
    endtask

    task automatic test_reset_mid_wide();
        bus.out_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_imm = 8'hAB; bus.req0_wide = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk1("rst_mid_ready0", bus.req0_ready, 1'b0);
        tick();
        chk1("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk16("rst_mid_out_imm", bus.out_imm, 16'h0000);
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_imm = 8'h05; bus.req0_wide = 1'b0;
        #1;
        chk1("rst_mid_next_ready0", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        chk1("rst_mid_next_valid", bus.out_valid, 1'b1);
        chk16("rst_mid_next_imm", bus.out_imm, 16'h0005);
        chk1("rst_mid_next_id", bus.out_id, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk1("rst_mid_next_fall", bus.out_valid, 1'b0);
    endtask

    task automatic test_config();
        bus.out_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_imm = 8'h80; bus.req0_wide = 1'b0;
`ifdef IMM_ZERO_EXT_EN
        bus.req0_zext  = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        chk16("cfg_zext_imm", bus.out_imm, 16'h0080);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready  = 1'b0;
        bus.req0_zext  = 1'b0;
        bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        chk16("cfg_sext_imm", bus.out_imm, 16'hFF80);
`else
        tick();
        bus.req0_valid = 1'b0;
        chk16("cfg_default_imm", bus.out_imm, 16'hFF80);
`endif
        bus.out_ready = 1'b1;
        tick();
        chk1("cfg_fall", bus.out_valid, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_imm = 8'h00; bus.req0_wide = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_imm = 8'h00; bus.req1_wide = 1'b0;
`ifdef IMM_ZERO_EXT_EN
        bus.req0_zext = 1'b0;
        bus.req1_zext = 1'b0;
`endif
        bus.out_ready = 1'b0;
        test_reset();
        test_narrow();
        test_round_robin();
        test_wide();
        test_backpressure();
        test_reset_mid_wide();
        test_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shares the single 8-to-16-bit sign-extension unit between two immediate requesters: the decode stage (port 0) and the branch-offset unit (port 1). Arbitration is round-robin. The block also builds full 16-bit "wide" immediates from two consecutive byte beats sent by one requester, and returns one registered 16-bit result per request through a valid/ready output handshake. It sits between instruction decode and the accumulator/register-file write path.

## Interface
- No parameters; widths are fixed (8-bit immediate in, 16-bit result out).
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 presents a beat
- req0_imm  in  8  requester 0 immediate byte
- req0_wide  in  1  beat is the high byte of a two-beat wide immediate
- req0_ready  out  1  requester 0 beat accepted this cycle when high with valid
- req1_valid, req1_imm, req1_wide, req1_ready  same as above, for requester 1
- ext_a  out  8  drive to SignExtend_8bit input a
- ext_r  in  16  from SignExtend_8bit output r
- out_valid  out  1  result available
- out_imm  out  16  result
- out_id  out  1  requester that owns the result
- out_ready  in  1  consumer accepts the result

## Operation
- States:
  - IDLE: no wide transfer open, no result pending.
  - WIDE_WAIT: high byte held, arbiter locked to its owner.
  - OUT_HOLD: result valid, waiting for the consumer.
- IDLE grant:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester selected by rr_ptr is granted.
  - Only the granted requester sees ready = 1.
- Narrow beat (wide = 0) accepted in IDLE:
  - ext_a = the granted imm.
  - out_imm <= ext_r, out_id <= grant.
  - Next state OUT_HOLD.
- Wide beat (wide = 1) accepted in IDLE:
  - hi_reg <= imm, owner <= grant.
  - Next state WIDE_WAIT.
- WIDE_WAIT:
  - ready = 1 only for the owner. The other requester is stalled with ready = 0.
  - The owner's next valid beat is the low byte; its wide flag is ignored.
  - out_imm <= {hi_reg, imm}. The extension unit is not used for this result.
  - Next state OUT_HOLD.
- OUT_HOLD:
  - Both ready outputs are 0.
  - On out_ready = 1: out_valid <= 0, next state IDLE.
- rr_ptr:
  - Flips to the other requester when a result completes (OUT_HOLD handshake).
  - Changes only when both requesters were contending at grant time; otherwise it is held.
- ext_a is combinational from the granted imm. It is 0 when there is no grant.
- Reset, including in the middle of an operation:
  - State to IDLE, hi_reg discarded.
  - out_valid = 0, out_imm = 16'h0000, out_id = 0, rr_ptr = 0 (requester 0 first).
  - Both ready outputs are 0 while reset is high.

## Timing
- Narrow request: accepted in cycle N, out_valid = 1 in cycle N+1.
- Wide request: high byte accepted in N, low byte accepted in M ≥ N+1, out_valid = 1 in M+1.
- out_imm and out_id stay stable from the rise of out_valid until the cycle after the out_ready handshake.
- No beat is accepted in the same cycle as an output handshake. Peak throughput is one narrow result per 2 cycles.
- valid may be held across stall cycles. A beat counts only on the edge where valid && ready.
- A valid from a non-owner requester during WIDE_WAIT or OUT_HOLD is not lost. It is served from IDLE afterwards.

## Configuration
- Macro IMM_ZERO_EXT_EN.
- Defined:
  - Adds input ports req0_zext and req1_zext (1 bit each).
  - A narrow beat with zext = 1 produces {8'h00, imm}, and ext_r is ignored for that beat.
  - Wide beats ignore zext.
- Undefined:
  - The zext ports are absent.
  - Every narrow beat is sign-extended through ext_r.

## Test plan
- Narrow sign extension: reset, then req0 narrow 8'h80 accepted in cycle N -> out_valid in N+1 with out_imm = 16'hFF80, out_id = 0. Then req1 narrow 8'h7F -> 16'h007F, out_id = 1.
- Contention and round-robin: req0 (8'h01) and req1 (8'h02) held valid together, out_ready tied to 1 -> results in order 16'h0001 (id 0), 16'h0002 (id 1), then with fresh beats 16'h0001 (id 0) again. No starvation.
- Wide transfer with stalled rival:
  - req1 sends high byte 8'h12, then 3 idle cycles, then low byte 8'hF4.
  - Required: out_imm = 16'h12F4, out_id = 1.
  - req0_valid is held high throughout and req0_ready stays 0 until req1 completes.
- Output backpressure: out_ready held 0 for 5 cycles while a result is pending -> out_imm and out_id stable, both ready outputs 0. Release out_ready -> out_valid falls next cycle.
- Reset while in WIDE_WAIT:
  - Assert reset after the high byte 8'hAB -> out_valid = 0 and out_imm = 16'h0000 after the reset edge.
  - A following req0 narrow 8'h05 -> 16'h0005, with no trace of 8'hAB.
- Configuration: IMM_ZERO_EXT_EN defined, narrow 8'h80 with zext = 1 -> 16'h0080. With the macro undefined, the same beat -> 16'hFF80.
